// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite codes, slave FSM state type and byte-lane strobe helper
// for the SRAM slave family.
package ahb_sram_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RWAIT,
        ST_RDATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Little-endian lane mask for up to 8 byte lanes; oversize HSIZE is
    // rejected by the error check, so its mask value never matters.
    function automatic logic [7:0] lane_strobe(input logic [2:0] size,
                                               input logic [2:0] offset);
        logic [15:0] mask;
        mask = ((16'd1 << (16'd1 << size)) - 16'd1) << offset;
        return mask[7:0];
    endfunction

endpackage

// File: rtl/ahb_sram_slave_bank.sv
// MEM_DEPTH x DATA_WIDTH storage with per-byte write enables and a
// registered read port that holds its value between reads.
module ahb_sram_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 4096
) (
    input  logic                         clk,
    input  logic [DATA_WIDTH/8-1:0]      we,
    input  logic [$clog2(MEM_DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic                         re,
    input  logic [$clog2(MEM_DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]        rdata
);

    localparam int BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Read-before-write: a same-edge read sees the old word; the top level
    // patches in the new bytes when it needs them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES; i++) begin
            if (we[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: transfer FSM, read wait counter, accept-time error
// check and read-after-write bypass around the ahb_sram_bank array.
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 4096,
    parameter int READ_WAIT  = 0,
    parameter int BASE_MASK  = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  s_HREADY,
    output logic [1:0]            s_HRESP,
    output logic [DATA_WIDTH-1:0] s_HRDATA
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(BYTES);
    localparam int IDX_BITS  = $clog2(MEM_DEPTH);

    state_t                state, state_next;
    logic [1:0]            wait_cnt, wait_cnt_next;
    logic [IDX_BITS-1:0]   wr_idx;
    logic [BYTES-1:0]      wr_strb;
    logic                  byp_valid;
    logic [DATA_WIDTH-1:0] byp_data;
    logic [BYTES-1:0]      byp_strb;
    logic [DATA_WIDTH-1:0] bank_rdata, rdata_hold, merged;

    logic                  accept, req_err, wr_fire, rd_fire, bypass_hit;
    logic [31:0]           word_full, size_mask;
    logic [IDX_BITS-1:0]   addr_idx;
    logic [7:0]            strb_all;
    logic [BYTES-1:0]      req_strb, bank_we;
    logic                  unused_bits;

    assign accept    = HSEL & HTRANS[1] & HREADY;
    assign word_full = 32'(HADDR[BASE_MASK-1:LANE_BITS]);
    assign addr_idx  = word_full[IDX_BITS-1:0];
    assign size_mask = (32'd1 << HSIZE) - 32'd1;
    assign strb_all  = lane_strobe(HSIZE, 3'(HADDR[LANE_BITS-1:0]));
    assign req_strb  = strb_all[BYTES-1:0];

    assign req_err = (word_full >= 32'(MEM_DEPTH))
                   | ((32'd8 << HSIZE) > 32'(DATA_WIDTH))
                   | ((HADDR & size_mask) != 32'd0);

    assign wr_fire    = (state == ST_WRITE) & HREADY;
    assign rd_fire    = accept & ~req_err & ~HWRITE;
    assign bypass_hit = wr_fire & rd_fire & (wr_idx == addr_idx);
    assign bank_we    = wr_fire ? wr_strb : '0;

    assign unused_bits = ^{HBURST, HTRANS[0], strb_all};

    ahb_sram_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_bank (
        .clk   (HCLK),
        .we    (bank_we),
        .waddr (wr_idx),
        .wdata (HWDATA),
        .re    (rd_fire),
        .raddr (addr_idx),
        .rdata (bank_rdata)
    );

    // Lanes written by the overlapping write override the stale array word.
    always_comb begin
        merged = bank_rdata;
        for (int i = 0; i < BYTES; i++) begin
            if (byp_valid && byp_strb[i]) begin
                merged[8*i +: 8] = byp_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            ST_ERR1: state_next = ST_ERR2;
            ST_RWAIT: begin
                if (wait_cnt == 2'd0) begin
                    state_next = ST_RDATA;
                end else begin
                    wait_cnt_next = wait_cnt - 2'd1;
                end
            end
            default: begin
                if (accept) begin
                    if (req_err) begin
                        state_next = ST_ERR1;
                    end else if (HWRITE) begin
                        state_next = ST_WRITE;
                    end else if (READ_WAIT > 0) begin
                        state_next    = ST_RWAIT;
                        wait_cnt_next = 2'(READ_WAIT - 1);
                    end else begin
                        state_next = ST_RDATA;
                    end
                end else if (HREADY) begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= ST_IDLE;
            wait_cnt   <= 2'd0;
            wr_idx     <= '0;
            wr_strb    <= '0;
            byp_valid  <= 1'b0;
            byp_data   <= '0;
            byp_strb   <= '0;
            rdata_hold <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (accept) begin
                wr_idx    <= addr_idx;
                wr_strb   <= req_strb;
                byp_valid <= bypass_hit;
                byp_data  <= HWDATA;
                byp_strb  <= wr_strb;
            end
            if (state == ST_RDATA) begin
                rdata_hold <= merged;
            end
        end
    end

    assign s_HREADY = (state != ST_RWAIT) && (state != ST_ERR1);
    assign s_HRESP  = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign s_HRDATA = (state == ST_RDATA) ? merged : rdata_hold;

endmodule
